// File: rtl/vga_pkg.sv
// Shared constants and pixel types for the VGA level-overlay slice.
//   PIX_W             : pixel payload width {R,G,B}, 10 bits per channel
//   FRAME_W / FRAME_H : native frame geometry
//   COL_GREEN/COL_RED : bar colours (top 8 bits of a channel set, low 2 bits zero)
//   rgb30_t           : packed pixel with r, g, b fields
package vga_pkg;

   localparam int unsigned PIX_W   = 30;
   localparam int unsigned FRAME_W = 640;
   localparam int unsigned FRAME_H = 480;

   typedef struct packed {
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
   } rgb30_t;

   localparam rgb30_t COL_GREEN = '{r: 10'h000, g: 10'h3FC, b: 10'h000};
   localparam rgb30_t COL_RED   = '{r: 10'h3FC, g: 10'h000, b: 10'h000};

endpackage

// File: rtl/vga_level_overlay_if.sv
// Avalon-ST pixel stream bundle.
//   data          : {R[9:0],G[9:0],B[9:0]} pixel
//   startofpacket : first pixel of a frame
//   endofpacket   : last pixel of a frame
//   valid / ready : beat transfers when both are high
// master modport drives the beat and samples ready; slave is the receiver.
interface vga_level_overlay_if;
   import vga_pkg::*;

   logic [PIX_W-1:0] data;
   logic             startofpacket;
   logic             endofpacket;
   logic             valid;
   logic             ready;

   modport master (
      output data, startofpacket, endofpacket, valid,
      input  ready
   );

   modport slave (
      input  data, startofpacket, endofpacket, valid,
      output ready
   );

endinterface

// File: rtl/avalon_st_skid.sv
// Two-entry register slice for a valid/ready stream: an output register
// plus one skid register, giving full throughput with registered outputs.
//   clk, reset          : clock, synchronous active-high reset
//   in_data/in_valid    : upstream beat
//   in_ready            : low while the skid register holds a beat or in reset
//   out_data/out_valid  : registered downstream beat
//   out_ready           : downstream accepts the beat
module avalon_st_skid #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q, out_data_d;
   logic         skid_valid_q, skid_valid_d;
   logic [W-1:0] skid_data_q, skid_data_d;
   logic         accept;

   assign in_ready  = ~reset & ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      accept       = in_valid & in_ready;

      if (out_valid_q && !out_ready) begin
         // Output stalled: a beat accepted this cycle parks in the skid
         // register (it is empty, otherwise in_ready would be low).
         if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end
      end else if (skid_valid_q) begin
         // Output free: the parked beat goes first to keep arrival order.
         out_valid_d  = 1'b1;
         out_data_d   = skid_data_q;
         skid_valid_d = 1'b0;
      end else begin
         out_valid_d = accept;
         if (accept) begin
            out_data_d = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/vga_level_overlay.sv
// Pixel-stream stage that paints a horizontal audio-level bar over the
// bottom rows of each frame; every other pixel passes through unchanged.
//   clk, reset  : clock, synchronous active-high reset
//   level       : bar length in pixels (clamped to WIDTH)
//   level_valid : capture level into the pending register
//   snk         : upstream pixel stream (slave)
//   src         : downstream pixel stream (master), registered through a skid slice
// The bar length is latched per frame on the SOP beat, so a level update
// mid-frame only takes effect from the next frame.
module vga_level_overlay
   import vga_pkg::*;
#(
   parameter int unsigned WIDTH   = FRAME_W,
   parameter int unsigned HEIGHT  = FRAME_H,
   parameter int unsigned BAR_TOP = 440,
   parameter int unsigned WARN_X  = 480,
   parameter int unsigned LVL_W   = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [LVL_W-1:0]     level,
   input  logic                 level_valid,
   vga_level_overlay_if.slave   snk,
   vga_level_overlay_if.master  src
);

   localparam int unsigned      PAYLOAD_W  = PIX_W + 2;
   localparam logic [9:0]       X_LAST     = 10'(WIDTH - 1);
   localparam logic [8:0]       Y_LAST     = 9'(HEIGHT - 1);
   localparam logic [8:0]       BAR_Y      = 9'(BAR_TOP);
   localparam logic [9:0]       WARN_COL   = 10'(WARN_X);
   localparam logic [9:0]       LVL_MAX    = 10'(WIDTH);
   localparam logic [LVL_W-1:0] LVL_MAX_IN = LVL_W'(WIDTH);

   logic [9:0]           pend_lvl_q, pend_lvl_d;
   logic [9:0]           frame_lvl_q, frame_lvl_d;
   logic [9:0]           x_q, x_d;
   logic [8:0]           y_q, y_d;
   logic                 synced_q, synced_d;

   logic [9:0]           lvl_clamped;
   logic [9:0]           pix_x;
   logic [8:0]           pix_y;
   logic [9:0]           cur_lvl;
   logic                 cur_synced;
   logic                 in_bar;
   logic                 accept;
   rgb30_t               bar_col;
   logic [PIX_W-1:0]     pix_out;
   logic [PAYLOAD_W-1:0] skid_in;
   logic [PAYLOAD_W-1:0] skid_out;

   always_comb begin
      lvl_clamped = (level > LVL_MAX_IN) ? LVL_MAX : 10'(level);
      accept      = snk.valid & snk.ready;

      // x_q/y_q hold the position of the next beat; an SOP beat is (0,0)
      // whatever the counters say, which resynchronises them.
      pix_x = snk.startofpacket ? 10'd0 : x_q;
      pix_y = snk.startofpacket ? 9'd0  : y_q;

      // On the SOP beat the new frame level is the one being latched now.
      cur_lvl    = snk.startofpacket ? (level_valid ? lvl_clamped : pend_lvl_q)
                                     : frame_lvl_q;
      cur_synced = synced_q | snk.startofpacket;

      in_bar  = cur_synced && (pix_y >= BAR_Y) && (pix_x < cur_lvl);
      bar_col = (pix_x < WARN_COL) ? COL_GREEN : COL_RED;
      pix_out = snk.data;
      if (in_bar) begin
         pix_out = bar_col;
      end

      pend_lvl_d  = level_valid ? lvl_clamped : pend_lvl_q;
      frame_lvl_d = frame_lvl_q;
      x_d         = x_q;
      y_d         = y_q;
      synced_d    = synced_q;

      if (accept) begin
         if (snk.startofpacket) begin
            frame_lvl_d = cur_lvl;
            synced_d    = 1'b1;
         end
         if (pix_x == X_LAST) begin
            x_d = '0;
            y_d = (pix_y == Y_LAST) ? Y_LAST : pix_y + 9'd1;
         end else begin
            x_d = pix_x + 10'd1;
            y_d = pix_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_lvl_q  <= '0;
         frame_lvl_q <= '0;
         x_q         <= '0;
         y_q         <= '0;
         synced_q    <= 1'b0;
      end else begin
         pend_lvl_q  <= pend_lvl_d;
         frame_lvl_q <= frame_lvl_d;
         x_q         <= x_d;
         y_q         <= y_d;
         synced_q    <= synced_d;
      end
   end

   assign skid_in = {pix_out, snk.startofpacket, snk.endofpacket};

   avalon_st_skid #(
      .W (PAYLOAD_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   (skid_in),
      .in_valid  (snk.valid),
      .in_ready  (snk.ready),
      .out_data  (skid_out),
      .out_valid (src.valid),
      .out_ready (src.ready)
   );

   assign src.data          = skid_out[PAYLOAD_W-1:2];
   assign src.startofpacket = skid_out[1];
   assign src.endofpacket   = skid_out[0];

endmodule

// File: tb/tb_vga_level_overlay.sv
// Bench for vga_level_overlay on a reduced 80x16 frame (bar rows 12..15,
// red from column 60) so each frame is short.
module tb_vga_level_overlay;

   localparam int W     = 80;
   localparam int H     = 16;
   localparam int BT    = 12;
   localparam int WX    = 60;
   localparam int FRAME = W * H;
   localparam logic [29:0] GREEN = 30'h000FF000;
   localparam logic [29:0] RED   = 30'h3FC00000;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] level;
   logic       level_valid;

   vga_level_overlay_if snk_if ();
   vga_level_overlay_if src_if ();

   vga_level_overlay #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .BAR_TOP (BT),
      .WARN_X  (WX),
      .LVL_W   (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .level       (level),
      .level_valid (level_valid),
      .snk         (snk_if),
      .src         (src_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [29:0] data;
      logic        sop;
      logic        eop;
   } beat_t;

   typedef struct packed {
      beat_t       b;
      int unsigned cyc;
   } exp_t;

   beat_t       tx_q[$];
   exp_t        exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned rdy_pct  = 100;
   int unsigned vld_pct  = 100;
   bit          rnd_lvl  = 1'b0;
   bit          lv_req   = 1'b0;
   logic [9:0]  lv_val   = '0;
   int          lv_trig  = -1;
   logic [9:0]  lv_trig_val = '0;

   // reference model state
   int          m_pending, m_frame, m_idx;
   bit          m_synced;

   int          n_dlv, n_sop, n_eop, n_green, n_red, n_blocked;
   bit          prev_stall, prev_acc;
   logic [31:0] prev_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int clamp(input int l);
      return (l > W) ? W : l;
   endfunction

   // Expected pixel from frame geometry: beat index since SOP gives (x,y).
   function automatic logic [29:0] model_pix(input logic [29:0] d, input int idx,
                                             input int lvl, input bit synced);
      int x, y;
      x = idx % W;
      y = idx / W;
      if (y > H - 1) y = H - 1;
      if (synced && y >= BT && x < lvl) return (x < WX) ? GREEN : RED;
      return d;
   endfunction

   task automatic step();
      bit         pres, acc, dlv, lv;
      logic [9:0] lvv;
      beat_t      b;
      exp_t       e;
      @(negedge clk);
      pres = (tx_q.size() > 0) && ($urandom_range(99) < vld_pct);
      b    = pres ? tx_q[0] : '0;
      snk_if.valid         = pres;
      snk_if.data          = b.data;
      snk_if.startofpacket = b.sop;
      snk_if.endofpacket   = b.eop;
      src_if.ready         = ($urandom_range(99) < rdy_pct);
      lv     = lv_req;
      lvv    = lv_val;
      lv_req = 1'b0;
      if (pres && lv_trig >= 0 && tx_q.size() == lv_trig) begin
         lv      = 1'b1;
         lvv     = lv_trig_val;
         lv_trig = -1;
      end else if (!lv && rnd_lvl && $urandom_range(9) == 0) begin
         lv  = 1'b1;
         lvv = 10'($urandom_range(1023));
      end
      level_valid = lv;
      level       = lvv;
      #1;
      cyc++;

      if (prev_stall) begin
         chk("hold_valid", 32'(src_if.valid), 32'd1);
         chk("hold_data", {src_if.data, src_if.startofpacket, src_if.endofpacket}, prev_out);
         if (prev_acc) chk("bp_ready", 32'(snk_if.ready), 32'd0);
      end

      acc = pres && snk_if.ready;
      dlv = src_if.valid && src_if.ready;
      if (pres && !snk_if.ready) n_blocked++;

      if (dlv) begin
         if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(dlv), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("data", 32'(src_if.data), 32'(e.b.data));
            chk("sop", 32'(src_if.startofpacket), 32'(e.b.sop));
            chk("eop", 32'(src_if.endofpacket), 32'(e.b.eop));
            if (rdy_pct == 100) chk("latency", cyc - e.cyc, 32'd1);
         end
         n_dlv++;
         if (src_if.startofpacket) n_sop++;
         if (src_if.endofpacket)   n_eop++;
         if (src_if.data == GREEN) n_green++;
         if (src_if.data == RED)   n_red++;
      end

      if (acc) begin
         if (b.sop) begin
            m_synced = 1'b1;
            m_idx    = 0;
            m_frame  = lv ? clamp(int'(lvv)) : m_pending;
         end
         e.b.data = model_pix(b.data, m_idx, m_frame, m_synced);
         e.b.sop  = b.sop;
         e.b.eop  = b.eop;
         e.cyc    = cyc;
         exp_q.push_back(e);
         void'(tx_q.pop_front());
         m_idx++;
      end
      if (lv) m_pending = clamp(int'(lvv));

      prev_stall = src_if.valid && !src_if.ready;
      prev_acc   = acc;
      prev_out   = {src_if.data, src_if.startofpacket, src_if.endofpacket};
   endtask

   task automatic run(input int unsigned budget);
      int unsigned n = 0;
      while ((tx_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain", 32'(tx_q.size() + exp_q.size()), 32'd0);
      step();
   endtask

   task automatic queue_beats(input bit with_sop, input int first, input int n,
                              input bit rnd, input logic [29:0] fixed);
      beat_t b;
      for (int i = first; i < first + n; i++) begin
         b.data = rnd ? (30'($urandom) & 30'h3FCFF3FC) : fixed;
         if (b.data == GREEN || b.data == RED) b.data ^= 30'h100;
         b.sop = with_sop && (i == 0);
         b.eop = (i == FRAME - 1);
         tx_q.push_back(b);
      end
   endtask

   task automatic set_level(input logic [9:0] v);
      lv_req = 1'b1;
      lv_val = v;
      step();
   endtask

   task automatic clear_stats();
      n_dlv = 0; n_sop = 0; n_eop = 0; n_green = 0; n_red = 0; n_blocked = 0;
   endtask

   task automatic check_bar(input string tag, input int lvl);
      int l;
      l = clamp(lvl);
      chk({tag, "_green"}, 32'(n_green), 32'((H - BT) * ((l < WX) ? l : WX)));
      chk({tag, "_red"},   32'(n_red),   32'((H - BT) * ((l > WX) ? l - WX : 0)));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      snk_if.valid = 1'b0;
      level_valid  = 1'b0;
      src_if.ready = 1'b1;
      #1;
      chk("rst_snk_ready_low", 32'(snk_if.ready), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_src_valid", 32'(src_if.valid), 32'd0);
      chk("rst_src_data",  32'(src_if.data), 32'd0);
      chk("rst_src_sop",   32'(src_if.startofpacket), 32'd0);
      chk("rst_src_eop",   32'(src_if.endofpacket), 32'd0);
      chk("rst_snk_ready", 32'(snk_if.ready), 32'd1);
      tx_q.delete();
      exp_q.delete();
      m_pending = 0; m_frame = 0; m_idx = 0; m_synced = 1'b0;
      prev_stall = 1'b0; prev_acc = 1'b0;
   endtask

   initial begin
      int unsigned n;
      reset                = 1'b0;
      level                = '0;
      level_valid          = 1'b0;
      snk_if.valid         = 1'b0;
      snk_if.data          = '0;
      snk_if.startofpacket = 1'b0;
      snk_if.endofpacket   = 1'b0;
      src_if.ready         = 1'b1;
      clear_stats();
      do_reset();

      // plain frame, level never written: pass-through, 1-cycle latency
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b0, 30'h3FC3FC00);
      run(FRAME + 50);
      chk("t1_beats", 32'(n_dlv), 32'(FRAME));
      chk("t1_sop", 32'(n_sop), 32'd1);
      chk("t1_eop", 32'(n_eop), 32'd1);
      chk("t1_blocked", 32'(n_blocked), 32'd0);
      check_bar("t1", 0);

      // bar crossing the warn column
      set_level(10'd70);
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      run(FRAME + 50);
      chk("t2_beats", 32'(n_dlv), 32'(FRAME));
      check_bar("t2", 70);

      // oversize level clamps to a full row
      set_level(10'd1000);
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      run(FRAME + 50);
      check_bar("t3", 1000);

      // level change mid-frame only affects the next frame
      set_level(10'd10);
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      lv_trig     = FRAME - 6 * W;
      lv_trig_val = 10'd70;
      run(FRAME + 50);
      check_bar("t4_cur", 10);
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      run(FRAME + 50);
      check_bar("t4_next", 70);

      // random back-pressure, gaps and level writes over two frames
      rdy_pct = 50; vld_pct = 80; rnd_lvl = 1'b1;
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      run(8 * FRAME);
      chk("t5_beats", 32'(n_dlv), 32'(2 * FRAME));
      chk("t5_sop", 32'(n_sop), 32'd2);
      rdy_pct = 100; vld_pct = 100; rnd_lvl = 1'b0;

      // reset at pixel (10,6), then a headless partial frame, then a full one
      set_level(10'd70);
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      n = 0;
      while (tx_q.size() > FRAME - (6 * W + 10) && n < 2 * FRAME) begin
         step();
         n++;
      end
      chk("t6_reach", 32'(tx_q.size()), 32'(FRAME - (6 * W + 10)));
      do_reset();
      set_level(10'd70);
      clear_stats();
      queue_beats(1'b0, 6 * W + 20, FRAME - (6 * W + 20), 1'b1, '0);
      run(FRAME + 50);
      chk("t6_pass_green", 32'(n_green), 32'd0);
      chk("t6_pass_red", 32'(n_red), 32'd0);
      clear_stats();
      queue_beats(1'b1, 0, FRAME, 1'b1, '0);
      run(FRAME + 50);
      check_bar("t6_resync", 70);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_level_overlay.md
# vga_level_overlay

Avalon-ST pipeline stage between the face image generator and the VGA output module. Passes the 640x480 pixel stream through unchanged, except that it paints a horizontal audio-level bar across the bottom rows of each frame. The bar length comes from a level input sampled once per frame, so the bar never tears mid-frame. A skid buffer provides full-throughput back-pressure in both directions.

## Interface
- WIDTH, 640: pixels per row
- HEIGHT, 480: rows per frame
- BAR_TOP, 440: first row of the bar region (rows BAR_TOP..HEIGHT-1)
- WARN_X, 480: columns at or beyond this point are painted red instead of green
- LVL_W, 10: width of the level input
---
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- level  in  LVL_W  bar length in pixels; values above WIDTH are clamped to WIDTH
- level_valid  in  1  when high, level is captured into the pending register
- snk_data  in  30  upstream pixel: {R[9:0],G[9:0],B[9:0]}, with the low 2 bits of each channel zero
- snk_startofpacket  in  1  first pixel of the frame
- snk_endofpacket  in  1  last pixel of the frame
- snk_valid  in  1  upstream beat valid
- snk_ready  out  1  stage can accept a beat
- src_data  out  30  pixel to the VGA module
- src_startofpacket, src_endofpacket  out  1  forwarded with their beat
- src_valid  out  1  output beat valid
- src_ready  in  1  VGA module accepts the beat

## Operation
- A beat is accepted when snk_valid and snk_ready are both high.
- A beat is delivered when src_valid and src_ready are both high.
- Pending level register: loads min(level, WIDTH) on every cycle where level_valid is high.
- Frame level register:
  - Loads on each accepted SOP beat.
  - The value loaded is the pending level, or the live clamped input if level_valid is high in that same cycle.
- Position counters x (10 bit) and y (9 bit) track the pixel of the accepted beat:
  - An SOP beat is pixel (0,0), regardless of the current counter state. This resynchronises the counters.
  - After a non-SOP beat, x increments. At WIDTH-1, x wraps to 0 and y increments.
  - y saturates at HEIGHT-1.
- synced flag:
  - Cleared by reset.
  - Set by the first accepted SOP beat.
  - While the flag is clear, beats pass through unmodified.
- Overlay rule, applied when synced, y >= BAR_TOP and x < frame level:
  - x < WARN_X: data becomes green, 30'h000FF000.
  - otherwise: data becomes red, 30'h3FC00000.
  - All other beats: data is forwarded unchanged.
- SOP and EOP always pass through unchanged.
- Downstream of the pixel decision there are two registers: a main output register and one skid register.
  - snk_ready = ~reset & ~skid_full.
  - When src_ready drops, the in-flight beat lands in the skid register.
  - The skid register drains before new beats are accepted.
- No beat is ever dropped or duplicated, and beats leave in arrival order.

## Timing
- Reset values: src_valid 0, snk_ready 0 (during reset), src_data 0, src_startofpacket 0, src_endofpacket 0, pending level 0, frame level 0, x 0, y 0, synced 0.
- The first cycle after reset deasserts has snk_ready = 1.
- Latency: an accepted beat appears on src one cycle later, provided src_ready was high.
- Throughput: 1 beat/cycle sustained whenever src_ready is held high.
- Back-pressure:
  - If src_ready is low on cycle N, snk_ready is low on cycle N+1 at the latest.
  - At most one extra beat is absorbed, into the skid register.
- src_valid only falls after its beat is delivered. src_data is stable while src_valid is high and src_ready is low.
- Reset mid-frame:
  - Both registers are flushed and all state returns to its reset values.
  - Output stays in pass-through until the next SOP.
- level_valid mid-frame: updates only the pending register; the bar in the current frame is unchanged.

## Structure
- Package vga_pkg holds:
  - constants PIX_W=30, FRAME_W=640, FRAME_H=480
  - colour constants COL_GREEN and COL_RED
  - typedef rgb30_t, a packed struct with r, g, b fields of 10 bits each
- Sub-module avalon_st_skid, parameterised on payload width (32 bits: data + SOP + EOP).
  - Contains the output register, the skid register and the ready logic.
  - vga_level_overlay instantiates it once, after the combinational overlay mux.

## Test plan
- Reset, then stream one full frame with all pixels 30'h3FC3FC00 and level = 0, src_ready = 1 → output identical to input, 307200 beats, exactly one SOP and one EOP, latency 1 cycle.
- level = 500 before SOP → rows 440..479: x 0..479 = 30'h000FF000, x 480..499 = 30'h3FC00000, x >= 500 unchanged; rows 0..439 unchanged.
- level = 1000 → clamped to 640; bar spans the full row, all columns >= 480 red.
- level changed from 100 to 600 at pixel (0,300) → current frame bar ends at x = 99; next frame bar ends at x = 599.
- Random src_ready toggling (50%) over 2 frames → output sequence matches a reference model beat-for-beat, no loss or duplication, src_data stable while stalled.
- Reset asserted at pixel (10,200), then a stream starts mid-frame without SOP → pass-through until SOP; the following frame has its bar correct at y = 440.
